// File: rtl/base_rrarb_lock.sv
// Round-robin arbiter with packet lock.
// Grants the first requester at or after ptr, or the locked way while a packet
// is in flight. Releases the lock and advances ptr past the winner on the
// end-of-packet handshake.
module base_rrarb_lock #(
  parameter  int ways      = 4,
  localparam int sel_width = (ways > 1) ? $clog2(ways) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ways-1:0]      req,
  input  logic                 eop,
  input  logic                 act,
  output logic [sel_width-1:0] gnt
);

  localparam logic [sel_width-1:0] last_way = sel_width'(ways - 1);

  logic [sel_width-1:0] ptr;
  logic [sel_width-1:0] lock_way;
  logic                 lock;
  logic [sel_width-1:0] search_gnt;
  int                   idx;

  // Rotating priority search starting at ptr; lower offsets override higher ones.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment, so no latch is inferred.
    search_gnt = ptr;
    idx        = 0;
    for (int i = ways - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= ways) idx = idx - ways;
      if (req[idx]) search_gnt = sel_width'(idx);
    end
    gnt = lock ? lock_way : search_gnt;
  end

  // Lock and pointer update on each accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      lock     <= 1'b0;
      lock_way <= '0;
    end else if (act) begin
      // NOTE: non-blocking assignments keep every register updated from pre-edge values.
      if (eop) begin
        lock <= 1'b0;
        ptr  <= (gnt == last_way) ? '0 : gnt + 1'b1;
      end else begin
        lock     <= 1'b1;
        lock_way <= gnt;
      end
    end
  end

endmodule

// File: rtl/base_arealign_rrmux.sv
// Round-robin arbiter/multiplexer for split-timing streams.
// The adv field is muxed by the live grant; the del field, which arrives one
// cycle after its handshake, is muxed by the grant registered at that handshake.
module base_arealign_rrmux #(
  parameter  int ways      = 4,
  parameter  int adv_width = 1,
  parameter  int del_width = 1,
  localparam int sel_width = (ways > 1) ? $clog2(ways) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ways-1:0]           i_v,
  input  logic [ways-1:0]           i_e,
  input  logic [ways*adv_width-1:0] i_d_adv,
  input  logic [ways*del_width-1:0] i_d_del,
  output logic [ways-1:0]           i_r,
  output logic                      o_v,
  output logic                      o_e,
  output logic [adv_width-1:0]      o_d_adv,
  output logic [del_width-1:0]      o_d_del,
  output logic [sel_width-1:0]      o_sel,
  input  logic                      o_r
);

  logic [sel_width-1:0] gnt;
  logic [sel_width-1:0] del_sel;
  logic                 act;

  assign act   = o_v & o_r;
  assign o_sel = gnt;

  base_rrarb_lock #(.ways(ways)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (i_v),
    .eop   (o_e),
    .act   (act),
    .gnt   (gnt)
  );

  // Adv-path mux and per-way ready; o_v never looks at o_r.
  always_comb begin
    o_v     = i_v[0];
    o_e     = i_e[0];
    o_d_adv = i_d_adv[0 +: adv_width];
    i_r     = '0;
    for (int k = 0; k < ways; k++) begin
      if (gnt == sel_width'(k)) begin
        o_v     = i_v[k];
        o_e     = i_e[k];
        o_d_adv = i_d_adv[k*adv_width +: adv_width];
        i_r[k]  = o_r & i_v[k];
      end
    end
  end

  // Del-path mux driven by the grant captured at the previous handshake.
  always_comb begin
    o_d_del = i_d_del[0 +: del_width];
    for (int k = 0; k < ways; k++) begin
      if (del_sel == sel_width'(k)) o_d_del = i_d_del[k*del_width +: del_width];
    end
  end

  // Remember which way handshook so its del data is selected next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    del_sel <= '0;
    else if (act) del_sel <= gnt;
  end

endmodule

// File: doc/base_arealign_rrmux.md
Name: base_arealign_rrmux

Overview:
- N-way round-robin arbiter and multiplexer for split-timing streams.
- The "adv" field is valid in the cycle where valid and ready are both high; the "del" field arrives one cycle later.
- Each requester port and the single output port follow this timing. A downstream realigner can therefore re-join the adv and del fields.
- Packets are atomic: once a requester wins, it holds the output until its end-of-packet beat is accepted.

Parameters:
- ways, 4, number of requester ports (>=1).
- adv_width, 1, width of per-beat data valid in the handshake cycle.
- del_width, 1, width of per-beat data valid one cycle after the handshake.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_v  input  ways  per-requester valid.
- i_e  input  ways  per-requester end-of-packet flag; qualified by i_v.
- i_d_adv  input  ways*adv_width  per-requester adv data; way k is at slice [k*adv_width +: adv_width].
- i_d_del  input  ways*del_width  per-requester del data; valid one cycle after that way's handshake.
- i_r  output  ways  per-requester ready.
- o_v  output  1  output valid.
- o_e  output  1  end-of-packet flag of the selected beat.
- o_d_adv  output  adv_width  selected adv data.
- o_d_del  output  del_width  selected del data; valid one cycle after the output handshake.
- o_sel  output  max(1,clog2(ways))  index of the currently granted way.
- o_r  input  1  downstream ready.

Behaviour:
- State:
  - ptr: round-robin pointer, reset 0.
  - lock: mid-packet flag, reset 0.
  - lock_way: locked requester index, reset 0.
  - del_sel: registered grant index for the del mux, reset 0.
- Grant (combinational, zero added latency on the adv path):
  - If lock=1: gnt = lock_way.
  - If lock=0: gnt = first k with i_v[k]=1, searching ptr, ptr+1, ... ptr+ways-1 mod ways.
  - If no i_v is set: gnt = ptr.
- Output and ready:
  - o_v = i_v[gnt].
  - o_e = i_e[gnt].
  - o_d_adv = slice gnt of i_d_adv.
  - o_sel = gnt.
  - i_r[k] = o_r & (k==gnt) & i_v[k].
  - o_v must not depend on o_r. i_r may depend on i_v of all ways.
- Handshake: act = o_v & o_r, which equals i_v[gnt] & i_r[gnt].
  - act & o_e: lock <= 0; ptr <= (gnt+1) mod ways, wrapping ways-1 -> 0.
  - act & ~o_e: lock <= 1; lock_way <= gnt; ptr unchanged.
  - no act: lock, lock_way and ptr hold.
  - act: del_sel <= gnt. Otherwise del_sel holds.
- Del path:
  - o_d_del = slice del_sel of i_d_del, combinational.
  - Adds no latency: the del data of beat n appears on o_d_del in the cycle after beat n's handshake.
  - In cycles not following a handshake, o_d_del is the held-select mux output; downstream ignores it.
- Back-to-back packets:
  - A handshake on way A in cycle t followed by a handshake on way B in cycle t+1 is legal.
  - In cycle t+1, o_d_del carries A's del data; del_sel updates to B at the end of t+1.
- Locked requester drops i_v mid-packet: o_v=0, no other way is granted, lock holds until that way resumes.
- Single-beat packets (i_e=1 on the first beat) never set lock.
- ways=1: gnt is always 0 and ptr stays 0; the block behaves as a wire with a del pass-through.
- Reset asserted mid-packet:
  - All state returns to reset values immediately.
  - Outputs become combinational functions of the inputs with lock=0 and ptr=0.
  - Any partially sent packet is abandoned; recovery is upstream's responsibility.
- Reset values of outputs:
  - With all i_v=0 during reset: o_v=0, i_r=0, o_sel=0, o_e=0.
  - o_d_adv and o_d_del select way 0.

Decomposition:
- No shared package: the index width is derived locally with clog2 and there are no typedefs.
- One natural sub-module, base_rrarb_lock: round-robin arbiter holding ptr, lock and lock_way.
  - Inputs: req, end, act.
  - Output: gnt index.
  - The mux and del_sel register stay in the top level.

Test Plan (ways=4, adv_width=8, del_width=8, o_r=1 unless noted):
1. All i_v=1, all i_e=1, constant → grants cycle 0,1,2,3,0; o_d_del in cycle t+1 equals i_d_del of way o_sel(t).
2. Way 2 sends a 3-beat packet (i_e on beat 3) while ways 0,1,3 request → o_sel=2 for 3 consecutive handshakes; next grant is way 3, then 0.
3. Way 1 locked after beat 1, drops i_v for 2 cycles while ways 0 and 3 request → o_v=0 for those 2 cycles, i_r=0 for all ways; beat 2 of way 1 is accepted on return.
4. o_r low for 3 cycles with ways 0 and 2 requesting, ptr=0 → o_sel holds 0, o_v=1, no state change; o_d_adv is stable; first handshake goes to way 0.
5. Reset asserted asynchronously while way 3 is locked mid-packet → lock clears within the same cycle; after release, ptr=0 and way 0 wins if requesting.
6. Way 0 handshakes at t with i_d_del(t+1)=0xA5; way 1 handshakes at t+1 with i_d_del(t+2)=0x3C → o_d_del=0xA5 at t+1, 0x3C at t+2.
